// File: rtl/mac_job_sequencer_if.sv
// -----------------------------------------------------------------------------
// mac_job_sequencer_if
//
// Bundles the operand stream, the vector/result bus to the 16-lane dot-product
// MAC, and the result stream of mac_job_sequencer.
//
//   slave  : the sequencer itself
//   master : everything around it (operand source, MAC, result consumer)
//
// Signals
//   in_valid/in_ready/in_a/in_b/in_last  operand-pair stream into the sequencer
//   vec_a/vec_b                          N x DW vectors driven to the MAC
//   mac_result                           RW-bit dot product returned by the MAC
//   out_valid/out_ready/out_result       result stream out of the sequencer
//   out_err                              job closed on lane count, no in_last
//   busy                                 a job is in progress
// -----------------------------------------------------------------------------
interface mac_job_sequencer_if #(
  parameter int N  = 16,
  parameter int DW = 32,
  parameter int RW = 64
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_a;
  logic signed [DW-1:0] in_b;
  logic                 in_last;

  // Lane k of each vector is the k-th accepted pair of the job.
  logic [N-1:0][DW-1:0] vec_a;
  logic [N-1:0][DW-1:0] vec_b;
  logic signed [RW-1:0] mac_result;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [RW-1:0] out_result;
  logic                 out_err;
  logic                 busy;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mac_result, out_ready,
    output in_ready, vec_a, vec_b, out_valid, out_result, out_err, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mac_result, out_ready,
    input  in_ready, vec_a, vec_b, out_valid, out_result, out_err, busy
  );

endinterface

// File: rtl/mac_job_sequencer.sv
// -----------------------------------------------------------------------------
// mac_job_sequencer
//
// Initiator-side front end of the pipelined dot-product MAC. Operand pairs are
// accepted one per cycle and written into consecutive lanes of the A/B vector
// registers. A job closes on in_last or when the last lane is filled. The
// vectors are then held for MAC_LAT edges, the MAC output is captured, and the
// result is offered on the output stream until taken. Taking the result clears
// all lanes, so a short job leaves its unused lanes at zero.
//
// Parameters
//   N        lanes per vector (power of two)
//   DW       signed operand width
//   RW       signed result width; must equal the MAC output width
//   MAC_LAT  edges the vectors are held before sampling mac_result (1..255)
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   mac_job_sequencer_if.slave (operand stream, MAC bus, result stream)
// -----------------------------------------------------------------------------
module mac_job_sequencer #(
  parameter int N       = 16,
  parameter int DW      = 32,
  parameter int RW      = 64,
  parameter int MAC_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_job_sequencer_if.slave    bus
);

  localparam int             IW     = $clog2(N);
  localparam logic [7:0]     LAT_M1 = 8'(MAC_LAT - 1);
  localparam logic [IW-1:0]  LAST_LANE_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT,
    S_OUT
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        idx_q;
  logic [7:0]           cnt_q;
  logic                 err_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_err_q;
  logic signed [RW-1:0] out_result_q;
  logic [N-1:0][DW-1:0] vec_a_q;
  logic [N-1:0][DW-1:0] vec_b_q;

  logic                 accept;
  logic                 last_lane;
  logic                 close_job;
  logic                 take_result;
  logic [IW-1:0]        idx_d;

  // in_ready_q is only ever set while in FILL, so it alone qualifies an accept.
  assign accept      = in_ready_q & bus.in_valid;
  assign last_lane   = (idx_q == LAST_LANE_IDX);
  assign close_job   = accept & (bus.in_last | last_lane);
  assign take_result = out_valid_q & bus.out_ready;
  assign idx_d       = idx_q + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      // in_ready stays low through reset and rises on the first edge after it.
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
      // NOTE: the lanes are plain flops, not a RAM, so resetting them is cheap
      // and it is what guarantees a zero vector to the MAC after reset.
      vec_a_q      <= '0;
      vec_b_q      <= '0;
    end else begin
      // NOTE: every state register here uses <=, so all of them update from the
      // same pre-edge values regardless of statement order.
      unique case (state_q)
        S_FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            vec_a_q[idx_q] <= bus.in_a;
            vec_b_q[idx_q] <= bus.in_b;
            if (close_job) begin
              // Running out of lanes without in_last is a framing error.
              err_q      <= last_lane & ~bus.in_last;
              idx_q      <= '0;
              cnt_q      <= LAT_M1;
              in_ready_q <= 1'b0;
              state_q    <= S_WAIT;
            end else begin
              idx_q <= idx_d;
            end
          end
        end

        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            out_result_q <= bus.mac_result;
            out_err_q    <= err_q;
            out_valid_q  <= 1'b1;
            state_q      <= S_OUT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        S_OUT: begin
          if (take_result) begin
            // Clearing here is what zero-fills the unused lanes of a short job.
            vec_a_q     <= '0;
            vec_b_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_FILL;
          end
        end

        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.vec_a      = vec_a_q;
  assign bus.vec_b      = vec_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_err    = out_err_q;
  // Decoded from registers only; no input reaches busy combinationally.
  assign bus.busy       = (state_q != S_FILL) || (idx_q != '0);

endmodule

// File: tb/tb_mac_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_job_sequencer
//
// Self-checking bench for mac_job_sequencer. Contains a behavioural MAC (dot
// product of the presented vectors, registered twice) so the sampled value is
// correct only when the sequencer samples exactly MAC_LAT edges after closing.
// Directed jobs come from a table; multi-cycle corners are hand-written; a
// random phase is scored against job-level expectations built from the stream
// of accepted pairs.
// -----------------------------------------------------------------------------
module tb_mac_job_sequencer;

  localparam int N       = 16;
  localparam int DW      = 32;
  localparam int RW      = 64;
  localparam int MAC_LAT = 3;
  localparam int WAIT_BOUND = 100;

  typedef logic [N-1:0][DW-1:0] vec_t;

  typedef struct {
    string                name;
    int                   len;
    bit                   use_last;
    vec_t                 a;
    vec_t                 b;
    logic signed [RW-1:0] exp_result;
    logic                 exp_err;
  } job_vec_t;

  typedef struct {
    vec_t                 a;
    vec_t                 b;
    logic signed [RW-1:0] sum;
    logic                 err;
  } exp_job_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mac_job_sequencer_if #(.N(N), .DW(DW), .RW(RW)) bus ();

  mac_job_sequencer #(
    .N(N), .DW(DW), .RW(RW), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed dot product of the first len lanes, wrapping at RW bits.
  function automatic logic signed [RW-1:0] dot(input vec_t a, input vec_t b, input int len);
    logic signed [RW-1:0] s;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    s = '0;
    for (int k = 0; k < len; k++) begin
      x = a[k];
      y = b[k];
      s += RW'(x) * RW'(y);
    end
    return s;
  endfunction

  // MAC model: combinational dot followed by two register stages.
  logic signed [RW-1:0] mac_p1;
  logic signed [RW-1:0] mac_p2;
  always @(posedge clk) begin
    mac_p1 <= dot(bus.vec_a, bus.vec_b, N);
    mac_p2 <= mac_p1;
  end
  assign bus.mac_result = mac_p2;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Called and returns just after a falling edge.
  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    while (!bus.in_ready && guard < WAIT_BOUND) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) fail_bound("send_pair");
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic feed_job(input vec_t a, input vec_t b, input int len, input bit use_last);
    for (int k = 0; k < len; k++)
      send_pair(a[k], b[k], use_last && (k == len - 1));
  endtask

  // Returns the number of edges from the closing edge to out_valid.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < WAIT_BOUND) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) fail_bound("wait_result");
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    job_vec_t             tbl[5];
    exp_job_t             expq[$];
    exp_job_t             e;
    exp_job_t             cur;
    vec_t                 va;
    vec_t                 vb;
    logic signed [RW-1:0] exp_sum;
    int                   lat;
    int                   cur_len;
    int                   jobs_done;
    bit                   have_pair;
    logic [DW-1:0]        pa;
    logic [DW-1:0]        pb;
    logic                 pl;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tbl[i].a = '0;
      tbl[i].b = '0;
    end
    tbl[0].name = "full";    tbl[0].len = 16; tbl[0].use_last = 1'b1;
    tbl[0].exp_result = 64'sd272; tbl[0].exp_err = 1'b0;
    for (int k = 0; k < N; k++) begin
      tbl[0].a[k] = DW'(k + 1);
      tbl[0].b[k] = 32'd2;
    end
    tbl[1].name = "short";   tbl[1].len = 3;  tbl[1].use_last = 1'b1;
    tbl[1].exp_result = 64'sd13; tbl[1].exp_err = 1'b0;
    tbl[1].a[0] = 32'd5;     tbl[1].b[0] = -32'sd4;
    tbl[1].a[1] = 32'd7;     tbl[1].b[1] = 32'd3;
    tbl[1].a[2] = -32'sd2;   tbl[1].b[2] = -32'sd6;
    tbl[2].name = "no_last"; tbl[2].len = 16; tbl[2].use_last = 1'b0;
    tbl[2].exp_result = -64'sd120; tbl[2].exp_err = 1'b1;
    for (int k = 0; k < N; k++) begin
      tbl[2].a[k] = DW'(k);
      tbl[2].b[k] = 32'hFFFF_FFFF;
    end
    // 16 * 2^62 wraps to exactly zero in 64 bits.
    tbl[3].name = "extreme"; tbl[3].len = 16; tbl[3].use_last = 1'b1;
    tbl[3].exp_result = 64'sd0; tbl[3].exp_err = 1'b0;
    for (int k = 0; k < N; k++) begin
      tbl[3].a[k] = 32'h8000_0000;
      tbl[3].b[k] = 32'h8000_0000;
    end
    // -2^31 * (2^31-1) = -2^62 + 2^31: a negative value using all 64 bits.
    tbl[4].name = "sign";    tbl[4].len = 1;  tbl[4].use_last = 1'b1;
    tbl[4].exp_result = 64'hC000_0000_8000_0000; tbl[4].exp_err = 1'b0;
    tbl[4].a[0] = 32'h8000_0000;
    tbl[4].b[0] = 32'h7FFF_FFFF;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst in_ready",   bus.in_ready,   1'b0);
    check("rst out_valid",  bus.out_valid,  1'b0);
    check("rst out_result", bus.out_result, 64'd0);
    check("rst out_err",    bus.out_err,    1'b0);
    check("rst busy",       bus.busy,       1'b0);
    check("rst vec_a",      bus.vec_a,      '0);
    check("rst vec_b",      bus.vec_b,      '0);
    rst = 1'b0;
    // out_ready with nothing to take must be ignored.
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post-rst in_ready",  bus.in_ready,  1'b1);
    check("post-rst out_valid", bus.out_valid, 1'b0);

    // ---------------- table-driven jobs ----------------
    for (int i = 0; i < 5; i++) begin
      feed_job(tbl[i].a, tbl[i].b, tbl[i].len, tbl[i].use_last);
      wait_result(lat);
      check({tbl[i].name, " latency"},    lat,            MAC_LAT);
      check({tbl[i].name, " result"},     bus.out_result, tbl[i].exp_result);
      check({tbl[i].name, " err"},        bus.out_err,    tbl[i].exp_err);
      check({tbl[i].name, " vec_a"},      bus.vec_a,      tbl[i].a);
      check({tbl[i].name, " vec_b"},      bus.vec_b,      tbl[i].b);
      check({tbl[i].name, " in_ready"},   bus.in_ready,   1'b0);
      check({tbl[i].name, " busy"},       bus.busy,       1'b1);
      take_result();
      check({tbl[i].name, " done valid"}, bus.out_valid,  1'b0);
      check({tbl[i].name, " done ready"}, bus.in_ready,   1'b1);
      check({tbl[i].name, " done vec_a"}, bus.vec_a,      '0);
      check({tbl[i].name, " done busy"},  bus.busy,       1'b0);
    end

    // ---------------- missing in_last, 17th pair held off ----------------
    for (int k = 0; k < N; k++) begin
      va[k] = DW'(k + 10);
      vb[k] = DW'(k - 3);
    end
    feed_job(va, vb, N, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h0000_1234;
    bus.in_b     = -32'sd5;
    bus.in_last  = 1'b0;
    wait_result(lat);
    check("p17 latency",    lat,            MAC_LAT);
    check("p17 err",        bus.out_err,    1'b1);
    check("p17 result",     bus.out_result, dot(va, vb, N));
    check("p17 held vec_a", bus.vec_a,      va);
    take_result();
    check("p17 cleared vec_a", bus.vec_a,    '0);
    check("p17 in_ready",      bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    va = '0;
    vb = '0;
    va[0] = 32'h0000_1234;
    vb[0] = -32'sd5;
    check("p17 lane0 vec_a", bus.vec_a, va);
    check("p17 lane0 vec_b", bus.vec_b, vb);
    check("p17 busy",        bus.busy,  1'b1);
    send_pair(32'd7, 32'd7, 1'b1);
    va[1] = 32'd7;
    vb[1] = 32'd7;
    wait_result(lat);
    check("p17 job2 result", bus.out_result, dot(va, vb, 2));
    check("p17 job2 err",    bus.out_err,    1'b0);
    take_result();

    // ---------------- output backpressure ----------------
    for (int k = 0; k < N; k++) begin
      va[k] = DW'(3 * k - 7);
      vb[k] = DW'(k + 100);
    end
    exp_sum = dot(va, vb, N);
    feed_job(va, vb, N, 1'b1);
    wait_result(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp out_valid",  bus.out_valid,  1'b1);
      check("bp out_result", bus.out_result, exp_sum);
      check("bp vec_a",      bus.vec_a,      va);
      check("bp vec_b",      bus.vec_b,      vb);
      check("bp in_ready",   bus.in_ready,   1'b0);
    end
    take_result();
    check("bp after in_ready", bus.in_ready,  1'b1);
    check("bp after vec_a",    bus.vec_a,     '0);
    check("bp after valid",    bus.out_valid, 1'b0);

    // ---------------- reset in WAIT ----------------
    feed_job(tbl[0].a, tbl[0].b, N, 1'b1);
    rst = 1'b1;
    #1;
    check("rw out_valid",  bus.out_valid,  1'b0);
    check("rw vec_a",      bus.vec_a,      '0);
    check("rw vec_b",      bus.vec_b,      '0);
    check("rw out_result", bus.out_result, 64'd0);
    check("rw in_ready",   bus.in_ready,   1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rw release in_ready",  bus.in_ready,  1'b1);
    check("rw release out_valid", bus.out_valid, 1'b0);
    for (int k = 0; k < N; k++) begin
      va[k] = 32'd1;
      vb[k] = 32'd1;
    end
    feed_job(va, vb, N, 1'b1);
    wait_result(lat);
    check("rw next result", bus.out_result, 64'sd16);
    check("rw next err",    bus.out_err,    1'b0);
    take_result();

    // ---------------- randomized jobs vs. job-level model ----------------
    cur.a     = '0;
    cur.b     = '0;
    cur.sum   = '0;
    cur.err   = 1'b0;
    cur_len   = 0;
    jobs_done = 0;
    have_pair = 1'b0;
    pa = '0;
    pb = '0;
    pl = 1'b0;
    for (int cyc = 0; cyc < 20000 && jobs_done < 40; cyc++) begin
      if (!have_pair) begin
        pa = rand_operand();
        pb = rand_operand();
        pl = ($urandom_range(0, 5) == 0);
        have_pair = 1'b1;
      end
      bus.in_a      = pa;
      bus.in_b      = pb;
      bus.in_last   = pl;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) begin
        cur.a[cur_len] = pa;
        cur.b[cur_len] = pb;
        cur.sum += RW'($signed(pa)) * RW'($signed(pb));
        cur_len++;
        have_pair = 1'b0;
        if (pl || cur_len == N) begin
          cur.err = !pl;
          expq.push_back(cur);
          cur.a   = '0;
          cur.b   = '0;
          cur.sum = '0;
          cur_len = 0;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          fail_bound("rnd unexpected result");
        end else begin
          e = expq.pop_front();
          check("rnd result", bus.out_result, e.sum);
          check("rnd err",    bus.out_err,    e.err);
          check("rnd vec_a",  bus.vec_a,      e.a);
          check("rnd vec_b",  bus.vec_b,      e.b);
        end
        jobs_done++;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    check("rnd jobs completed", (jobs_done >= 40), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_job_sequencer.md
# mac_job_sequencer

Initiator-side front end for the 16-lane pipelined dot-product MAC. It accepts operand pairs one per cycle over a valid/ready stream and assembles them into the A/B vector registers that drive the MAC. Once the vectors are assembled, it holds them stable for a fixed latency window, then captures the MAC result. The result is returned over a valid/ready output stream with a framing-error flag.

## Interface
- N, 16, number of lanes (vector length)
- DW, 32, operand width, signed
- RW, 64, result width, signed
- MAC_LAT, 3, clock edges the vectors are held before the MAC result is sampled; legal range 1..255

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair
- in_a  in  DW  signed A operand
- in_b  in  DW  signed B operand
- in_last  in  1  final pair of this job
- vec_a  out  N x DW  A vector to MAC; lane k = k-th accepted pair of the job
- vec_b  out  N x DW  B vector to MAC
- mac_result  in  RW  MAC dot-product output
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  RW  captured dot product
- out_err  out  1  job closed by lane count without in_last
- busy  out  1  state is not FILL, or idx is nonzero

## Operation
- **FSM states:** FILL, WAIT, OUT. Reset state is FILL.
- **FILL:**
  - in_ready=1.
  - On each in_valid&in_ready edge, in_a/in_b are written to lane idx and idx increments (idx is a log2(N)-bit counter).
  - The job closes on the accepting edge when in_last=1 or idx==N-1, whichever comes first.
  - On close: err_r <= (idx==N-1 && !in_last), idx <= 0, wait counter <= MAC_LAT-1, state -> WAIT.
- **Short jobs:** in_last before lane N-1 leaves the remaining lanes at zero, because lanes are cleared at job start. This is legal and sets out_err=0.
- **WAIT:**
  - in_ready=0; vec_a/vec_b held constant.
  - The counter decrements each edge.
  - On the edge where counter==0: out_result <= mac_result, out_err <= err_r, state -> OUT.
- **OUT:**
  - out_valid=1; out_result and out_err held; vectors still held; in_ready=0.
  - On the out_valid&out_ready edge: all vec_a/vec_b lanes are cleared to 0 and state -> FILL.
- **Arithmetic:** no arithmetic on operands. out_result is a straight register copy of mac_result; no sign extension or truncation. RW must equal the MAC output width.
- **Reset values:**
  - in_ready=0 during rst, then 1 after release (state FILL).
  - vec_a, vec_b all lanes 0.
  - out_valid=0, out_result=0, out_err=0, busy=0.
  - idx=0, wait counter=0.
- **Reset mid-operation:** asynchronous assertion in any state returns to FILL immediately. All vectors and outputs are zeroed, and any partially assembled job or pending result is discarded.

## Timing
- in_ready is a registered state decode. There is no combinational path from out_ready or in_valid to in_ready.
- Full N-element job: pairs accepted on N consecutive edges with in_valid held high.
- out_valid rises exactly MAC_LAT edges after the edge that accepts the closing pair.
- The MAC sees stable vectors from the closing edge until the result handshake, at least MAC_LAT cycles.
- The result-handshake edge returns to FILL; in_ready=1 in the next cycle. Back-to-back job throughput is N+MAC_LAT+1 cycles per job with out_ready tied high.
- in_valid while in_ready=0 is ignored; the source must hold the data.
- out_ready while out_valid=0 is ignored.
- in_last with in_valid=0 has no effect.

## Test plan
- **Full job:** A[k]=k+1, B[k]=2 for k=0..15, in_last on k=15; bench MAC model returns the sum after 3 cycles. Required: out_result=272, out_err=0, out_valid rises 3 edges after the last accept.
- **Short job:** 3 pairs (5,-4),(7,3),(-2,-6), in_last on the 3rd. Required: vec lanes 3..15 = 0, out_result=-20+21+12=13, out_err=0.
- **Missing in_last:** 16 pairs, all with in_last=0. Required: job closes at lane 15, out_err=1. The 17th pair offered is not accepted until after the result handshake, then lands in lane 0 of the next job with all other lanes 0.
- **Output backpressure:** out_ready low for 5 cycles after out_valid. Required: out_valid, out_result and vectors held constant; in_ready=0 throughout. Handshake on cycle 6; in_ready=1 the following cycle and vectors read 0.
- **Reset mid-WAIT:** assert rst 1 cycle after closing a full job. Required: immediately out_valid=0, vectors 0, out_result=0, in_ready=1 after release. The next 16-pair job (A=1, B=1) gives 16.
- **Extreme operands:** A=-2^31, B=-2^31 in all lanes. Required: out_result equals the bench MAC's 64-bit value bit-for-bit, with no sign alteration by the sequencer.
